event_record_buffer: RTL
========================

// Module: event_record_buffer
// PURPOSE
//  Downstream of the trigger handler. On each rising edge of the accepted trigger it captures
//  {timestamp, TOT_LONG, TOT_SHORT} into a FIFO of 64-bit records in block RAM.
//  Keeps run counters: triggers, dropped events and live-time ticks.
//  The I2C command interface drains records one at a time and reads the counters.
// PARAMETERS
//  ADDR_W   8    FIFO address width; depth = 2**ADDR_W records (256)
//  TS_W     32   free-running timestamp width, CLK ticks
//  CNT_W    32   width of NTRIGGERS, NDROPPED, LIVE_TIME
// PORTS
//  CLK          in   1       fast acquisition clock; all logic on posedge
//  RESET        in   1       asynchronous, active-high; clears all state
//  CLEAR        in   1       synchronous clear: same effect as RESET, applied on the next edge
//  TRIGGER_IN   in   1       accepted-trigger level (TRIGGER_OUT of the trigger handler)
//  LIVE_IN      in   1       live-acquisition level
//  TOT_SHORT    in   16      short-window TOT value
//  TOT_LONG     in   16      long-window TOT value
//  RD_REQ       in   1       one-cycle pop request from the readout side
//  RD_DATA      out  64      {TS[31:0], TOT_LONG, TOT_SHORT} of the last popped record
//  RD_VALID     out  1       one-cycle pulse; RD_DATA updated this cycle
//  FIFO_COUNT   out  ADDR_W+1  number of records stored
//  EMPTY        out  1       FIFO_COUNT == 0
//  FULL         out  1       FIFO_COUNT == 2**ADDR_W
//  OVERFLOW     out  1       sticky; set on the first dropped event
//  NTRIGGERS    out  CNT_W   trigger edges seen (stored + dropped)
//  NDROPPED     out  CNT_W   trigger edges lost because the FIFO was full
//  LIVE_TIME    out  CNT_W   CLK cycles with LIVE_IN = 1
// BEHAVIOUR
//  Reset values (RESET or CLEAR):
//   - all outputs 0 except EMPTY = 1
//   - write/read pointers, TS counter and trigger delay register = 0
//   - RAM contents are not cleared
//  Timestamp: TS increments by 1 every cycle and wraps modulo 2**TS_W; no flag on wrap.
//  Edge detect: TRIG_D <= TRIGGER_IN.
//   - STROBE = TRIGGER_IN & ~TRIG_D, evaluated at each clock edge
//   - a trigger held high for N cycles gives exactly one STROBE
//  Capture, on an edge where STROBE = 1:
//   - record = {TS (value before increment), TOT_LONG, TOT_SHORT}, sampled at that edge
//   - if the FIFO is not full: write record at WPTR, then WPTR++
//   - otherwise: NDROPPED++ and OVERFLOW <= 1
//   - NTRIGGERS++ in both cases
//   - FIFO_COUNT reflects the write one cycle after the edge
//  Pop: RD_REQ sampled high while not EMPTY
//   - RAM read at RPTR, RPTR++
//   - RD_DATA and RD_VALID appear 2 cycles after the RD_REQ edge
//     (1-cycle RAM latency + output register)
//   - RD_DATA holds its value until the next pop
//   - RD_REQ while EMPTY is ignored: no RD_VALID, pointers unchanged
//  Pointers are ADDR_W+1 bits:
//   - EMPTY when WPTR == RPTR
//   - FULL when the address bits match and the MSBs differ
//   - pointers wrap naturally
//  Simultaneous STROBE and RD_REQ:
//   - EMPTY: push accepted, pop ignored; a later RD_REQ returns the record
//   - FULL: pop accepted and push dropped (FULL is evaluated before the pop);
//     FIFO_COUNT drops by 1, NDROPPED++
//   - otherwise: both accepted, FIFO_COUNT unchanged
//  Counters (NTRIGGERS, NDROPPED, LIVE_TIME) saturate at all-ones and never wrap.
//  RESET mid-pop: the pending RD_VALID is cancelled. CLEAR has priority over STROBE and RD_REQ.
//  TRIGGER_IN already high when RESET deasserts: TRIG_D resets to 0, so one STROBE fires
//  on the first edge (intended).
// TESTING
//  1. Single event: TRIGGER_IN high 5 cycles at TS = 100, TOT_SHORT = 0x0012, TOT_LONG = 0x0340
//     -> FIFO_COUNT = 1, NTRIGGERS = 1
//     -> RD_REQ gives RD_VALID 2 cycles later, RD_DATA = 0x00000064_0340_0012
//  2. Fill: 257 trigger pulses, no reads
//     -> FULL = 1, FIFO_COUNT = 256, NDROPPED = 1, OVERFLOW = 1, NTRIGGERS = 257
//     -> 256 pops return TS in ascending order, then EMPTY = 1
//  3. Empty pop: RD_REQ with EMPTY = 1 -> no RD_VALID, FIFO_COUNT stays 0
//     Same-edge STROBE + RD_REQ on empty -> FIFO_COUNT = 1
//  4. Full + same-edge STROBE + RD_REQ -> FIFO_COUNT = 255, NDROPPED++, RD_VALID with the oldest record
//  5. LIVE_IN high 1000 cycles -> LIVE_TIME = 1000
//     Preload NTRIGGERS = 0xFFFFFFFF via force, one more trigger -> stays 0xFFFFFFFF
//  6. RESET asserted asynchronously mid-pop -> RD_VALID = 0 immediately, all counters 0, EMPTY = 1
//     CLEAR pulse -> same state one cycle later

Source files
------------

// File: rtl/event_record_buffer.sv
// event_record_buffer
//   Captures one 64-bit record {TS[31:0], TOT_LONG, TOT_SHORT} into a block-RAM FIFO
//   on every rising edge of the accepted trigger. It also keeps saturating run counters
//   for triggers, dropped events and live-time ticks. The readout side pops records
//   one at a time.
//
// Ports
//   CLK, RESET (async, active-high), CLEAR (sync, same effect as RESET)
//   TRIGGER_IN, LIVE_IN, TOT_SHORT[15:0], TOT_LONG[15:0]  acquisition inputs
//   RD_REQ                      one-cycle pop request
//   RD_DATA[63:0], RD_VALID     popped record, valid pulse (2 cycles after RD_REQ)
//   FIFO_COUNT, EMPTY, FULL     FIFO occupancy
//   OVERFLOW                    sticky, set on first dropped event
//   NTRIGGERS, NDROPPED, LIVE_TIME  saturating run counters
module event_record_buffer #(
    parameter int ADDR_W = 8,
    parameter int TS_W   = 32,   // must be >= 32; the record holds TS[31:0]
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic              TRIGGER_IN,
    input  logic              LIVE_IN,
    input  logic [15:0]       TOT_SHORT,
    input  logic [15:0]       TOT_LONG,
    input  logic              RD_REQ,
    output logic [63:0]       RD_DATA,
    output logic              RD_VALID,
    output logic [ADDR_W:0]   FIFO_COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              OVERFLOW,
    output logic [CNT_W-1:0]  NTRIGGERS,
    output logic [CNT_W-1:0]  NDROPPED,
    output logic [CNT_W-1:0]  LIVE_TIME
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [63:0]      mem [DEPTH];
    logic [63:0]      ram_q_reg;

    logic [TS_W-1:0]  ts_reg;
    logic             trig_d_reg;
    logic [ADDR_W:0]  wptr_reg;
    logic [ADDR_W:0]  rptr_reg;
    logic             rd_pend_reg;     // RAM read issued last cycle
    logic [63:0]      rd_data_reg;
    logic             rd_valid_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] ntriggers_reg;
    logic [CNT_W-1:0] ndropped_reg;
    logic [CNT_W-1:0] live_time_reg;

    logic             strobe;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [63:0]      record;

    assign strobe = TRIGGER_IN & ~trig_d_reg;
    assign empty  = (wptr_reg == rptr_reg);
    assign full   = (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]) &&
                    (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]);

    // CLEAR wins over any push/pop on the same edge. FULL/EMPTY are the
    // pre-edge values, so a pop on a full FIFO still drops the push.
    assign push   = strobe & ~full & ~CLEAR;
    assign drop   = strobe &  full & ~CLEAR;
    assign pop    = RD_REQ & ~empty & ~CLEAR;
    assign record = {ts_reg[31:0], TOT_LONG, TOT_SHORT};

    // Block RAM: contents are intentionally never cleared.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr_reg[ADDR_W-1:0]] <= record;
        end
    end

    // Registered RAM read. Push and pop never hit the same address on one edge.
    // A push needs a slot free and a pop needs a record stored.
    always_ff @(posedge CLK) begin
        if (pop) begin
            ram_q_reg <= mem[rptr_reg[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ts_reg        <= '0;
            trig_d_reg    <= 1'b0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            rd_pend_reg   <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            ntriggers_reg <= '0;
            ndropped_reg  <= '0;
            live_time_reg <= '0;
        end else if (CLEAR) begin
            ts_reg        <= '0;
            trig_d_reg    <= 1'b0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            rd_pend_reg   <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            ntriggers_reg <= '0;
            ndropped_reg  <= '0;
            live_time_reg <= '0;
        end else begin
            ts_reg     <= ts_reg + 1'b1;
            trig_d_reg <= TRIGGER_IN;

            if (push) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_reg <= rptr_reg + 1'b1;
            end

            // Output stage: RD_DATA holds until the next pop completes.
            rd_pend_reg  <= pop;
            rd_valid_reg <= rd_pend_reg;
            if (rd_pend_reg) begin
                rd_data_reg <= ram_q_reg;
            end

            if (drop) begin
                overflow_reg <= 1'b1;
                if (ndropped_reg != '1) begin
                    ndropped_reg <= ndropped_reg + 1'b1;
                end
            end
            if (strobe && (ntriggers_reg != '1)) begin
                ntriggers_reg <= ntriggers_reg + 1'b1;
            end
            if (LIVE_IN && (live_time_reg != '1)) begin
                live_time_reg <= live_time_reg + 1'b1;
            end
        end
    end

    assign RD_DATA    = rd_data_reg;
    assign RD_VALID   = rd_valid_reg;
    assign FIFO_COUNT = wptr_reg - rptr_reg;
    assign EMPTY      = empty;
    assign FULL       = full;
    assign OVERFLOW   = overflow_reg;
    assign NTRIGGERS  = ntriggers_reg;
    assign NDROPPED   = ndropped_reg;
    assign LIVE_TIME  = live_time_reg;

endmodule
